// File: rtl/seq_detector_param.sv
// ============================================================================
// Module      : seq_detector_param
// Description : Runtime-programmable serial pattern detector. Shifts in one
//               bit per qualified clock and flags every occurrence of a
//               loadable 1..MAX_LEN bit pattern, with overlapping or
//               non-overlapping matching and a saturating match counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   system clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   inp          in   serial data bit
//   in_valid     in   inp is sampled only when high
//   cfg_load     in   capture cfg_* into the shadow config (wins over sampling)
//   cfg_pattern  in   pattern, bit[len-1] oldest bit, bit[0] newest bit
//   cfg_len      in   pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//   cfg_overlap  in   1 = overlapping matches allowed
//   cnt_clr      in   synchronous clear of match_cnt
//   out          out  registered match indication
//   match_cnt    out  saturating match count
// Optional feature macro: SEQ_DET_HOLD_EN
//   Defined   : out is level-held from a match until RELEASE_ZEROS consecutive
//               valid 0 samples have followed it.
//   Undefined : out is a one-cycle pulse per match.
// ============================================================================
`default_nettype none

module seq_detector_param #(
  parameter int                 MAX_LEN       = 8,
  parameter int                 LEN_W         = 4,
  parameter int                 CNT_W         = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT   = MAX_LEN'(8'b0000_0110),
  parameter int                 DEFAULT_LEN   = 3,
  parameter int                 RELEASE_ZEROS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inp,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

  // Elaboration-time sanity checks on the parameter set.
  if (MAX_LEN < 2) begin : g_chk_max_len
    $error("seq_detector_param: MAX_LEN must be >= 2");
  end
  if ((1 << LEN_W) <= MAX_LEN) begin : g_chk_len_w
    $error("seq_detector_param: LEN_W too narrow for MAX_LEN");
  end
  if (RELEASE_ZEROS < 1) begin : g_chk_release
    $error("seq_detector_param: RELEASE_ZEROS must be >= 1");
  end

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) begin
      return c_one;
    end else if (l > c_max_len) begin
      return c_max_len;
    end else begin
      return l;
    end
  endfunction

  // Shadow configuration
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;

  // Datapath state
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;

  logic [MAX_LEN-1:0] w_shift;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_sample;
  logic               w_match;
  state_e             w_state;

  assign w_sample = in_valid & ~cfg_load;
  assign w_shift  = {hist_q[MAX_LEN-2:0], inp};

  // Only the low len_q bits of the window and pattern take part in the
  // compare; this also covers len=1 where the window is inp alone.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(len_q));
    end
  end

  // A full window is available once len-1 bits are held, since the
  // incoming bit completes it. len_q is never 0, so len_q-1 cannot wrap.
  always_comb begin
    w_state = (fill_q >= (len_q - c_one)) ? ST_ARMED : ST_FILL;
  end

  assign w_match = w_sample && (w_state == ST_ARMED) &&
                   (((w_shift ^ pat_q) & w_mask) == '0);

  always_comb begin
    pat_d     = pat_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;

    if (cfg_load) begin
      pat_d     = cfg_pattern;
      len_d     = clamp_len(cfg_len);
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (in_valid) begin
      hist_d = w_shift;
      fill_d = (fill_q == c_max_len) ? fill_q : fill_q + c_one;
      if (w_match) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Non-overlapping: discard the matched window so its bits are not
        // reused by the next match.
        if (!overlap_q) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end
  end

`ifdef SEQ_DET_HOLD_EN
  localparam int ZR_W = (RELEASE_ZEROS < 2) ? 1 : $clog2(RELEASE_ZEROS + 1);
  localparam logic [ZR_W-1:0] c_zr_last = ZR_W'(RELEASE_ZEROS - 1);

  logic [ZR_W-1:0] zrun_q, zrun_d;

  // Level-held output: set on a match, released after RELEASE_ZEROS
  // consecutive valid zeros; any valid 1 restarts the zero run.
  always_comb begin
    out_d  = out_q;
    zrun_d = zrun_q;
    if (cfg_load) begin
      out_d  = 1'b0;
      zrun_d = '0;
    end else if (in_valid) begin
      if (w_match) begin
        out_d  = 1'b1;
        zrun_d = '0;
      end else if (out_q) begin
        if (inp) begin
          zrun_d = '0;
        end else if (zrun_q == c_zr_last) begin
          out_d  = 1'b0;
          zrun_d = '0;
        end else begin
          zrun_d = zrun_q + ZR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zrun_q <= '0;
    end else begin
      zrun_q <= zrun_d;
    end
  end
`else
  always_comb begin
    out_d = w_match;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q     <= DEFAULT_PAT;
      len_q     <= clamp_len(LEN_W'(DEFAULT_LEN));
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      out_q     <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench for seq_detector_param. Directed stimulus
//               pushes hand-computed expected {out, match_cnt} into a queue;
//               a monitor pops and compares one entry per driven edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               rst;
  logic               inp;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;

  seq_detector_param #(
    .MAX_LEN      (MAX_LEN),
    .LEN_W        (LEN_W),
    .CNT_W        (CNT_W),
    .DEFAULT_PAT  (8'b0000_0110),
    .DEFAULT_LEN  (3),
    .RELEASE_ZEROS(2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .inp        (inp),
    .in_valid   (in_valid),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .out        (out),
    .match_cnt  (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [CNT_W:0] exp_q[$];
  string          name_q[$];

  // Monitor: one expected entry per driven edge, checked just after it.
  initial begin
    logic [CNT_W:0] e;
    string          nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (out !== e[CNT_W] || match_cnt !== e[CNT_W-1:0]) begin
          n_mis++;
          $display("FAIL %s: got out=%0b cnt=%0d, expected out=%0b cnt=%0d",
                   nm, out, match_cnt, e[CNT_W], e[CNT_W-1:0]);
        end
      end
    end
  end

  task automatic drive(input logic ld, input logic v, input logic b,
                       input logic clr, input logic eo, input int ec,
                       input string nm);
    @(negedge clk);
    cfg_load = ld;
    in_valid = v;
    inp      = b;
    cnt_clr  = clr;
    exp_q.push_back({eo, CNT_W'(ec)});
    name_q.push_back(nm);
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                      input logic ov, input int ec, input string nm);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ec, nm);
  endtask

  task automatic check_now(input string nm, input logic eo, input int ec);
    n_cmp++;
    if (out !== eo || match_cnt !== CNT_W'(ec)) begin
      n_mis++;
      $display("FAIL %s: got out=%0b cnt=%0d, expected out=%0b cnt=%0d",
               nm, out, match_cnt, eo, ec);
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inp = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_now("reset_state", 1'b0, 0);
    rst = 1'b0;

`ifdef SEQ_DET_HOLD_EN
    // Default 110: output held until two valid zeros follow the match.
    drive(0, 1, 1, 0, 0, 0, "hold_s1");
    drive(0, 1, 1, 0, 0, 0, "hold_s2");
    drive(0, 1, 0, 0, 1, 1, "hold_match");
    drive(0, 1, 0, 0, 1, 1, "hold_zero1");
    drive(0, 1, 0, 0, 0, 1, "hold_zero2_release");
    drive(0, 1, 1, 0, 0, 1, "hold_s6");
    drive(0, 1, 1, 0, 0, 1, "hold_s7");
    drive(0, 1, 0, 0, 1, 2, "hold_match2");
    drive(0, 1, 1, 0, 1, 2, "hold_one_restarts");
    drive(0, 0, 0, 0, 1, 2, "hold_gap");
    drive(0, 1, 0, 0, 1, 2, "hold_zero1b");
    drive(0, 1, 0, 0, 0, 2, "hold_zero2b_release");
    drive(0, 1, 1, 0, 0, 2, "hold_s13");
    drive(0, 1, 1, 0, 0, 2, "hold_s14");
    drive(0, 1, 0, 0, 1, 3, "hold_match3");
    load(8'b0000_0110, 4'd3, 1'b1, 3, "hold_load_clears");
`else
    // 1: reset defaults, pattern 110 overlapping
    drive(0, 1, 1, 0, 0, 0, "t1_s1");
    drive(0, 1, 1, 0, 0, 0, "t1_s2");
    drive(0, 1, 0, 0, 1, 1, "t1_match");
    drive(0, 1, 1, 0, 0, 1, "t1_s4");
    drive(0, 1, 1, 0, 0, 1, "t1_s5");
    drive(0, 1, 1, 0, 0, 1, "t1_s6");
    drive(0, 1, 0, 0, 1, 2, "t1_match2");
    drive(0, 0, 0, 1, 0, 0, "t1_clr");

    // 2: pattern 101, overlapping then non-overlapping
    load(8'b0000_0101, 4'd3, 1'b1, 0, "t2_load_ov");
    drive(0, 1, 1, 0, 0, 0, "t2_s1");
    drive(0, 1, 0, 0, 0, 0, "t2_s2");
    drive(0, 1, 1, 0, 1, 1, "t2_match_a");
    drive(0, 1, 0, 0, 0, 1, "t2_s4");
    drive(0, 1, 1, 0, 1, 2, "t2_match_b");
    drive(0, 0, 0, 0, 0, 2, "t2_idle");
    load(8'b0000_0101, 4'd3, 1'b0, 2, "t2_load_nov");
    drive(0, 0, 0, 1, 0, 0, "t2_clr");
    drive(0, 1, 1, 0, 0, 0, "t2n_s1");
    drive(0, 1, 0, 0, 0, 0, "t2n_s2");
    drive(0, 1, 1, 0, 1, 1, "t2n_match");
    drive(0, 1, 0, 0, 0, 1, "t2n_s4");
    drive(0, 1, 1, 0, 0, 1, "t2n_no_reuse");

    // 3: gaps are transparent to matching
    load(8'b0000_0110, 4'd3, 1'b1, 1, "t3_load");
    drive(0, 0, 0, 1, 0, 0, "t3_clr");
    drive(0, 1, 1, 0, 0, 0, "t3_s1");
    drive(0, 0, 1, 0, 0, 0, "t3_gap1");
    drive(0, 0, 0, 0, 0, 0, "t3_gap2");
    drive(0, 0, 1, 0, 0, 0, "t3_gap3");
    drive(0, 1, 1, 0, 0, 0, "t3_s2");
    drive(0, 1, 0, 0, 1, 1, "t3_match");

    // 4/5: len 0 clamps to 1; saturation; cnt_clr beats the increment
    load(8'b0000_0001, 4'd0, 1'b1, 1, "t4_load_len0");
    drive(0, 0, 0, 1, 0, 0, "t4_clr");
    drive(0, 1, 1, 0, 1, 1, "t4_m1");
    drive(0, 1, 0, 0, 0, 1, "t4_zero");
    drive(0, 1, 1, 0, 1, 2, "t4_m2");
    drive(0, 1, 1, 0, 1, 3, "t4_m3");
    drive(0, 1, 1, 0, 1, 3, "t5_sat_m4");
    drive(0, 1, 1, 0, 1, 3, "t5_sat_m5");
    drive(0, 1, 1, 1, 1, 0, "t5_clr_beats_inc");

    // 4: len 15 clamps to 8, pattern A5 matches only on the 8th bit
    load(8'hA5, 4'd15, 1'b1, 0, "t4_load_len15");
    drive(0, 1, 1, 0, 0, 0, "t4l_b7");
    drive(0, 1, 0, 0, 0, 0, "t4l_b6");
    drive(0, 1, 1, 0, 0, 0, "t4l_b5");
    drive(0, 1, 0, 0, 0, 0, "t4l_b4");
    drive(0, 1, 0, 0, 0, 0, "t4l_b3");
    drive(0, 1, 1, 0, 0, 0, "t4l_b2");
    drive(0, 1, 0, 0, 0, 0, "t4l_b1");
    drive(0, 1, 1, 0, 1, 1, "t4l_match");

    // 6: reset mid-stream restores defaults and drops partial history
    load(8'b0000_0110, 4'd3, 1'b1, 1, "t6_load");
    drive(0, 1, 1, 0, 0, 1, "t6_s1");
    drive(0, 1, 1, 0, 0, 1, "t6_s2");
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_now("t6_async_reset", 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 0, 0, 0, "t6_no_pulse");
    drive(0, 1, 1, 0, 0, 0, "t6_s4");
    drive(0, 1, 1, 0, 0, 0, "t6_s5");
    drive(0, 1, 0, 0, 1, 1, "t6_match_after_reset");
`endif

    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised, runtime-programmable serial pattern detector, the successor to the fixed 3-bit "110" detectors.
- Samples one bit per qualified clock and flags each occurrence of a loadable pattern of 1..MAX_LEN bits.
- Overlapping or non-overlapping match mode; saturating match counter.
- Sits on serial bit streams in the misc-logic datapath, feeding event counters and interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match_cnt
DEFAULT_PAT, 8'b0000_0110, pattern loaded at reset (low MAX_LEN bits used)
DEFAULT_LEN, 3, pattern length loaded at reset
RELEASE_ZEROS, 2, used only with SEQ_DET_HOLD_EN

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-high reset
inp  input  1  serial data bit
in_valid  input  1  inp sampled only when high
cfg_load  input  1  load cfg_* into shadow config this edge
cfg_pattern  input  MAX_LEN  pattern; bit[len-1] = first/oldest bit, bit[0] = last/newest bit
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping matches allowed
cnt_clr  input  1  synchronous clear of match_cnt
out  output  1  registered match pulse
match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Reset (async, immediate):
  - out=0, match_cnt=0, history hist=0, fill=0.
  - Shadow config: pat=DEFAULT_PAT, len=DEFAULT_LEN, overlap=1.
- Length clamp on load: eff_len = 1 if cfg_len==0; MAX_LEN if cfg_len>MAX_LEN; else cfg_len.
- Internal state:
  - hist: MAX_LEN-bit shift register, newest bit in hist[0].
  - fill: count of valid bits held, 0..MAX_LEN, saturating.
- FSM derived from fill:
  - FILL while fill < eff_len-1.
  - ARMED otherwise.
- Sample edge (in_valid=1, cfg_load=0):
  - Window W = {hist[eff_len-2:0], inp}; for eff_len=1, W = inp.
  - Match = ARMED and W == pat[eff_len-1:0].
  - hist <= {hist[MAX_LEN-2:0], inp}; fill <= min(fill+1, MAX_LEN).
  - On match:
    - out<=1 next cycle, for exactly one cycle (latency 1 clk after the sampling edge).
    - match_cnt += 1, saturating at all-ones.
    - If overlap=0: fill<=0 and hist<=0; bits of the matched window are not reused.
    - If overlap=1: history kept.
- in_valid=0, cfg_load=0: hist, fill and match_cnt hold; out<=0. Gaps are transparent to matching.
- cfg_load=1 (priority over sampling):
  - Shadow config <= clamped cfg_*; hist<=0, fill<=0, out<=0.
  - inp ignored that edge; match_cnt unaffected.
- cnt_clr=1: match_cnt<=0. It beats a simultaneous increment, but out still pulses for that match.
- Configuration changes take effect only through cfg_load; cfg_* are don't-care otherwise.
- Reset mid-stream: the partial history is lost; first possible match is eff_len valid bits after rst deasserts.

Optional Feature:
Macro SEQ_DET_HOLD_EN.
- Defined:
  - out becomes level-held instead of pulsed: set on match, cleared after RELEASE_ZEROS consecutive valid 0 samples following the match.
  - A valid 1 restarts the zero run.
  - A new match while held re-arms the run and still increments match_cnt.
  - cfg_load or rst clears out.
- Not defined: out is the one-cycle pulse above; RELEASE_ZEROS is unused.

Test Plan:
1. Reset defaults (110, len 3, overlap 1); valid stream 1,1,0 -> out=1 one cycle after the 3rd sample edge, match_cnt=1; stream 1,1,1,0 -> match_cnt=2.
2. cfg_load pat=3'b101 len=3 overlap=1; stream 1,0,1,0,1 -> two out pulses (after samples 3 and 5), match_cnt=2. Repeat with overlap=0 -> one pulse, match_cnt=1.
3. Stream 1,(in_valid=0 x3),1,0 with pattern 110 -> single pulse one cycle after the final 0; out stays 0 during the gaps.
4. cfg_load cfg_len=0, pattern bit0=1 -> every valid 1 pulses out. cfg_len=15 with MAX_LEN=8 -> behaves as len 8 (8'hA5 matches only after 8 bits).
5. CNT_W=2, five matches -> match_cnt=3. cnt_clr on the same edge as a 6th match -> match_cnt=0, out pulses.
6. rst asserted between samples 2 and 3 of "110" -> out=0 and match_cnt=0 immediately; no pulse on the following 0. With SEQ_DET_HOLD_EN: 1,1,0,0,0 -> out high from the match until 2 zeros are seen, then low.
